// File: rtl/mcp_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the N-way registered mux.
//   state_e : pipeline occupancy (EMPTY / ONE / TWO)
//   sel_w() : select width for an N-input mux, never below 1 bit
package mcp_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_e;

  function automatic int sel_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mcp_muxn_comb.sv
`timescale 1ns/1ps
// Purely combinational N-way word select with out-of-range flag.
// Usable on its own at datapath sites that need no register stage.
// Ports:
//   din     : N packed words, word k at din[k*WL +: WL]
//   sel     : source select
//   dout    : selected word, all-zero when sel >= N
//   sel_err : high when sel >= N
module mcp_muxn_comb #(
  parameter int WL    = 32,
  parameter int N     = 4,
  parameter int SEL_W = mcp_pkg::sel_w(N)
) (
  input  logic [N*WL-1:0] din,
  input  logic [SEL_W-1:0] sel,
  output logic [WL-1:0]   dout,
  output logic            sel_err
);

  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N);

  always_comb begin
    dout = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) dout = din[k*WL +: WL];
    end
  end

  assign sel_err = ({1'b0, sel} >= N_LIM);

endmodule

// File: rtl/mcp_muxn_pipe.sv
`timescale 1ns/1ps
// N-input registered mux with valid/ready handshake and a 2-entry skid
// buffer (main output register + one skid register), strict FIFO order.
//
//   state | meaning
//   ------+---------------------------------------------------
//   EMPTY | main and skid empty; OUT_VALID=0, IN_READY=1
//   ONE   | main holds a word; OUT_VALID=1, IN_READY=1
//   TWO   | main and skid hold words; OUT_VALID=1, IN_READY=0
//
// Ports:
//   CLK, RST_N          : clock (rising edge), async active-low reset
//   DIN, MUX_SEL        : packed sources and select, taken on accept
//   IN_VALID / IN_READY : upstream handshake (IN_READY is registered)
//   DOUT / OUT_VALID    : registered selected word and its valid
//   OUT_READY           : downstream consumes DOUT this cycle
//   SEL_ERR             : sticky, an out-of-range select was accepted
module mcp_muxn_pipe
  import mcp_pkg::*;
#(
  parameter int WL    = 32,
  parameter int N     = 4,
  parameter int SEL_W = sel_w(N)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N*WL-1:0]  DIN,
  input  logic [SEL_W-1:0] MUX_SEL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WL-1:0]    DOUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             SEL_ERR
);

  state_e          state_q, state_d;
  logic [WL-1:0]   dout_q, dout_d;
  logic [WL-1:0]   skid_q, skid_d;
  logic            sel_err_q, sel_err_d;
  logic            in_ready_q, in_ready_d;

  logic [WL-1:0]   word;
  logic            word_oob;
  logic            out_valid;
  logic            accept;
  logic            consume;

  mcp_muxn_comb #(
    .WL    (WL),
    .N     (N),
    .SEL_W (SEL_W)
  ) u_sel (
    .din     (DIN),
    .sel     (MUX_SEL),
    .dout    (word),
    .sel_err (word_oob)
  );

  // State register. IN_READY comes up only on the first edge after reset
  // release, and afterwards is a registered decode of the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= EMPTY;
      dout_q     <= '0;
      skid_q     <= '0;
      sel_err_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      skid_q     <= skid_d;
      sel_err_q  <= sel_err_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          dout_d  = word;
        end
      end
      ONE: begin
        if (accept && consume) begin
          dout_d = word;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = word;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          state_d = ONE;
          dout_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    sel_err_d  = sel_err_q | (accept & word_oob);
    in_ready_d = (state_d != TWO);
  end

  // Outputs and handshake qualifiers; all decoded from registers, so no
  // combinational path exists from OUT_READY to IN_READY.
  always_comb begin
    out_valid = (state_q != EMPTY);
    accept    = IN_VALID & in_ready_q;
    consume   = out_valid & OUT_READY;
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid;
  assign DOUT      = dout_q;
  assign SEL_ERR   = sel_err_q;

endmodule

// File: tb/tb_mcp_muxn_pipe.sv
`timescale 1ns/1ps
module tb_mcp_muxn_pipe;

  logic CLK;
  logic RST_N;

  // N=4 instance
  logic [127:0] din4;
  logic [1:0]   sel4;
  logic         iv4, ir4, ov4, or4, se4;
  logic [31:0]  dout4;

  // N=3 instance (has an out-of-range select code)
  logic [95:0]  din3;
  logic [1:0]   sel3;
  logic         iv3, ir3, ov3, or3, se3;
  logic [31:0]  dout3;

  int n_chk;
  int n_fail;

  mcp_muxn_pipe #(.WL(32), .N(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .DIN(din4), .MUX_SEL(sel4),
    .IN_VALID(iv4), .IN_READY(ir4), .DOUT(dout4), .OUT_VALID(ov4),
    .OUT_READY(or4), .SEL_ERR(se4)
  );

  mcp_muxn_pipe #(.WL(32), .N(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .DIN(din3), .MUX_SEL(sel3),
    .IN_VALID(iv3), .IN_READY(ir3), .DOUT(dout3), .OUT_VALID(ov3),
    .OUT_READY(or3), .SEL_ERR(se3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          iv;
    logic [1:0]  sel;
    bit          ordy;
    bit          e_ov;
    logic [31:0] e_dout;
    bit          e_ir;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    iv4 = 0; or4 = 0; sel4 = 0;
    iv3 = 0; or3 = 0; sel3 = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dout4", dout4, 32'h0);
    chk("rst_ov4", {31'b0, ov4}, 32'h0);
    chk("rst_se4", {31'b0, se4}, 32'h0);
    chk("rst_ov3", {31'b0, ov3}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    chk("rst_ir4_after_edge", {31'b0, ir4}, 32'h1);
  endtask

  // Behavioural model for the random phase: a FIFO of at most two words.
  logic [31:0] mq[$];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    RST_N  = 1'b0;
    din4   = {32'h33, 32'h22, 32'h11, 32'h00};
    din3   = {32'h22, 32'h11, 32'h00};
    iv4 = 0; or4 = 0; sel4 = 0;
    iv3 = 0; or3 = 0; sel3 = 0;

    //              iv sel ordy  ov  dout      ir
    tbl[0]  = '{1'b1, 2'd2, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h22, 1'b1};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[3]  = '{1'b1, 2'd1, 1'b0, 1'b0, 32'h00, 1'b1};
    tbl[4]  = '{1'b1, 2'd3, 1'b0, 1'b1, 32'h11, 1'b1};
    tbl[5]  = '{1'b1, 2'd0, 1'b0, 1'b1, 32'h11, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h11, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h33, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[9]  = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[10] = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h00, 1'b1};
    tbl[11] = '{1'b1, 2'd2, 1'b1, 1'b1, 32'h11, 1'b1};
    tbl[12] = '{1'b1, 2'd3, 1'b1, 1'b1, 32'h22, 1'b1};
    tbl[13] = '{1'b1, 2'd0, 1'b1, 1'b1, 32'h33, 1'b1};
    tbl[14] = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h00, 1'b1};
    tbl[15] = '{1'b1, 2'd2, 1'b1, 1'b1, 32'h11, 1'b1};
    tbl[16] = '{1'b1, 2'd3, 1'b1, 1'b1, 32'h22, 1'b1};
    tbl[17] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h33, 1'b1};
    tbl[18] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h00, 1'b1};

    do_reset();

    // Table: single word, skid/backpressure, streaming.
    for (int i = 0; i < 19; i++) begin
      iv4 = tbl[i].iv; sel4 = tbl[i].sel; or4 = tbl[i].ordy;
      @(negedge CLK);
      chk($sformatf("tbl%0d_ov", i), {31'b0, ov4}, {31'b0, tbl[i].e_ov});
      chk($sformatf("tbl%0d_ir", i), {31'b0, ir4}, {31'b0, tbl[i].e_ir});
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_dout", i), dout4, tbl[i].e_dout);
      tick();
    end

    // Input change after accept must not disturb main or skid.
    iv4 = 1; sel4 = 1; or4 = 0;
    @(negedge CLK);
    tick();
    iv4 = 0;
    din4[63:32] = 32'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("hold_dout", dout4, 32'h11);
      chk("hold_ov", {31'b0, ov4}, 32'h1);
      tick();
    end
    iv4 = 1; sel4 = 1;
    @(negedge CLK);
    tick();
    iv4 = 0; sel4 = 0; din4[63:32] = 32'h55; or4 = 1;
    @(negedge CLK);
    chk("skid_first_dout", dout4, 32'h11);
    chk("skid_ir", {31'b0, ir4}, 32'h0);
    tick();
    @(negedge CLK);
    chk("skid_second_dout", dout4, 32'hAA);
    tick();
    @(negedge CLK);
    chk("skid_drained_ov", {31'b0, ov4}, 32'h0);
    or4 = 0;
    tick();

    // Out-of-range select on N=3.
    iv3 = 1; sel3 = 3; or3 = 1;
    @(negedge CLK);
    chk("oob_pre_se", {31'b0, se3}, 32'h0);
    tick();
    sel3 = 1;
    @(negedge CLK);
    chk("oob_dout", dout3, 32'h0);
    chk("oob_ov", {31'b0, ov3}, 32'h1);
    chk("oob_se", {31'b0, se3}, 32'h1);
    tick();
    iv3 = 0;
    @(negedge CLK);
    chk("oob_next_dout", dout3, 32'h11);
    chk("oob_sticky1", {31'b0, se3}, 32'h1);
    tick();
    @(negedge CLK);
    chk("oob_empty_ov", {31'b0, ov3}, 32'h0);
    chk("oob_sticky2", {31'b0, se3}, 32'h1);
    tick();

    // Fill N=3 to TWO, then reset asynchronously between edges.
    or3 = 0; iv3 = 1; sel3 = 2;
    tick();
    sel3 = 0;
    tick();
    iv3 = 0;
    @(negedge CLK);
    chk("two_ir3", {31'b0, ir3}, 32'h0);
    chk("two_dout3", dout3, 32'h22);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_dout3", dout3, 32'h0);
    chk("async_ov3", {31'b0, ov3}, 32'h0);
    chk("async_se3", {31'b0, se3}, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    or3 = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("no_stale_ov3", {31'b0, ov3}, 32'h0);
      tick();
    end
    or3 = 0;

    // Randomised traffic on N=4 against a FIFO model.
    do_reset();
    mq.delete();
    for (int c = 0; c < 800; c++) begin
      bit e_ov, e_ir, acc, cons;
      din4 = {$urandom, $urandom, $urandom, $urandom};
      sel4 = 2'($urandom_range(0, 3));
      iv4  = ($urandom_range(0, 3) != 0);
      or4  = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      e_ov = (mq.size() > 0);
      e_ir = (mq.size() < 2);
      chk("rnd_ov", {31'b0, ov4}, {31'b0, e_ov});
      chk("rnd_ir", {31'b0, ir4}, {31'b0, e_ir});
      if (e_ov) chk("rnd_dout", dout4, mq[0]);
      acc  = iv4 && e_ir;
      cons = e_ov && or4;
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back(din4[sel4*32 +: 32]);
      tick();
    end
    chk("rnd_se4", {31'b0, se4}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
